// File: rtl/rf_wb_pkg.sv
// Shared constants, request type and hazard helper for the RF writeback arbiter.
// Build option: RF_WB_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package rf_wb_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned NUM_REG     = 32;
  localparam int unsigned NUM_REQ_MAX = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;

  // A register is busy while its write is pending or sitting in the output stage.
  // x0 is hardwired and therefore never busy.
  function automatic logic busy_of(input logic [REG_ADDR_W-1:0] r,
                                   input logic [NUM_REG-1:0]    pend,
                                   input logic                  wen,
                                   input logic [REG_ADDR_W-1:0] waddr);
    return (r != '0) && (pend[r] || (wen && (waddr == r)));
  endfunction

endpackage

// File: rtl/rr_arb.sv
// NUM_REQ-wide one-hot arbiter. Round-robin by default; with
// RF_WB_ARB_FIXED_PRIO_EN defined it collapses to a lowest-index-wins encoder.
// Grants are suppressed while i_rst is high.
module rr_arb #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef RF_WB_ARB_FIXED_PRIO_EN

  logic found;
  logic unused_clk;
  assign unused_clk = i_clk;

  // Lowest requesting index wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
      end
    end
    if (i_rst) gnt_o = '0;
  end

`else

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;
  int unsigned     pos;
  int unsigned     nxt;

  // Search from the pointer, wrapping modulo NUM_REQ; pointer moves past the winner.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    nxt   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = {{(32-PtrW){1'b0}}, ptr_q} + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = PtrW'(pos);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        nxt        = (pos + 1 == NUM_REQ) ? 0 : pos + 1;
        ptr_d      = PtrW'(nxt);
      end
    end
    if (i_rst) begin
      gnt_o = '0;
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: shares the single RF write port between
// NUM_REQ sources, registers the winner and tracks pending writes for hazards.
// Build option: RF_WB_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module rf_wb_arb
  import rf_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [5*NUM_REQ-1:0]       i_req_waddr,
  input  logic [32*NUM_REQ-1:0]      i_req_wdata,
  output logic                       o_rd_wen,
  output logic [4:0]                 o_rd_waddr,
  output logic [31:0]                o_rd_wdata,
  input  logic                       i_issue_valid,
  input  logic [4:0]                 i_issue_rd,
  input  logic [4:0]                 i_rs1_addr,
  input  logic [4:0]                 i_rs2_addr,
  output logic                       o_rs1_busy,
  output logic                       o_rs2_busy,
  output logic                       o_rd_busy
);

  wb_req_t               req [NUM_REQ];
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ-1:0]    gnt;
  logic                  hs;
  logic [REG_ADDR_W-1:0] sel_waddr;
  logic [XLEN-1:0]       sel_wdata;

  logic                  rd_wen_q, rd_wen_d;
  logic [REG_ADDR_W-1:0] rd_waddr_q, rd_waddr_d;
  logic [XLEN-1:0]       rd_wdata_q, rd_wdata_d;
  logic [NUM_REG-1:0]    pend_q, pend_d;

  // Unpack the flat request buses.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req[k].valid = i_req_valid[k];
      req[k].waddr = i_req_waddr[REG_ADDR_W*k +: REG_ADDR_W];
      req[k].wdata = i_req_wdata[XLEN*k +: XLEN];
      req_vld[k]   = req[k].valid;
    end
  end

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req_i (req_vld),
    .gnt_o (gnt)
  );

  // Grant only goes to a valid requester, so a set grant bit is the handshake.
  assign o_req_ready = gnt;

  // AND-OR select of the winning request's payload.
  always_comb begin
    hs        = |gnt;
    sel_waddr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_waddr = req[k].waddr;
        sel_wdata = req[k].wdata;
      end
    end
  end

  // Output stage next state: addr/data load on every handshake (x0 too), wen skips x0.
  always_comb begin
    rd_wen_d   = hs && (sel_waddr != '0);
    rd_waddr_d = hs ? sel_waddr : rd_waddr_q;
    rd_wdata_d = hs ? sel_wdata : rd_wdata_q;
  end

  // Scoreboard next state: clear on writeback handshake, then set on issue so set wins.
  always_comb begin
    pend_d = pend_q;
    if (hs) pend_d[sel_waddr] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) pend_d[i_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Output register and scoreboard state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_wen_q   <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      pend_q     <= '0;
    end else begin
      rd_wen_q   <= rd_wen_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
      pend_q     <= pend_d;
    end
  end

  assign o_rd_wen   = rd_wen_q;
  assign o_rd_waddr = rd_waddr_q;
  assign o_rd_wdata = rd_wdata_q;

  assign o_rs1_busy = busy_of(i_rs1_addr, pend_q, rd_wen_q, rd_waddr_q);
  assign o_rs2_busy = busy_of(i_rs2_addr, pend_q, rd_wen_q, rd_waddr_q);
  assign o_rd_busy  = busy_of(i_issue_rd, pend_q, rd_wen_q, rd_waddr_q);

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed steps followed by random traffic,
// compared against a transaction-level model of the arbiter and scoreboard.
module tb_rf_wb_arb;

  localparam int N = 3;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N-1:0]    i_req_valid = '0;
  logic [N-1:0]    o_req_ready;
  logic [5*N-1:0]  i_req_waddr = '0;
  logic [32*N-1:0] i_req_wdata = '0;
  logic            o_rd_wen;
  logic [4:0]      o_rd_waddr;
  logic [31:0]     o_rd_wdata;
  logic            i_issue_valid = 1'b0;
  logic [4:0]      i_issue_rd = '0;
  logic [4:0]      i_rs1_addr = '0;
  logic [4:0]      i_rs2_addr = '0;
  logic            o_rs1_busy;
  logic            o_rs2_busy;
  logic            o_rd_busy;

  rf_wb_arb #(.NUM_REQ(N)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_waddr   (i_req_waddr),
    .i_req_wdata   (i_req_wdata),
    .o_rd_wen      (o_rd_wen),
    .o_rd_waddr    (o_rd_waddr),
    .o_rd_wdata    (o_rd_wdata),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_rd_busy     (o_rd_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_ptr = 0;
  bit [31:0]   m_pend = '0;
  bit          m_wen = 1'b0;
  bit [4:0]    m_waddr = '0;
  bit [31:0]   m_wdata = '0;
  int          last_g;
  logic [N-1:0] obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int off = 0; off < N; off++) if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
`endif
    return -1;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && (m_pend[r] || (m_wen && m_waddr == r));
  endfunction

  // One clock: check everything against the model, clock, advance the model.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    logic [4:0] wa;
    #1;
    g  = i_rst ? -1 : pick(i_req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", o_req_ready, er);
    chk("wen", o_rd_wen, m_wen);
    chk("waddr", o_rd_waddr, m_waddr);
    chk("wdata", o_rd_wdata, m_wdata);
    chk("rs1_busy", o_rs1_busy, m_busy(i_rs1_addr));
    chk("rs2_busy", o_rs2_busy, m_busy(i_rs2_addr));
    chk("rd_busy", o_rd_busy, m_busy(i_issue_rd));
    obs_ready = o_req_ready;
    last_g = g;
    @(posedge i_clk);
    if (i_rst) begin
      m_ptr = 0; m_pend = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (g >= 0) begin
        wa      = i_req_waddr[5*g +: 5];
        m_wen   = (wa != 0);
        m_waddr = wa;
        m_wdata = i_req_wdata[32*g +: 32];
        m_pend[wa] = 1'b0;
        m_ptr   = (g + 1) % N;
      end else begin
        m_wen = 0;
      end
      if (i_issue_valid && i_issue_rd != 0) m_pend[i_issue_rd] = 1'b1;
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_seq;

    // Reset with every requester valid; first edge initialises the DUT unchecked.
    i_req_valid = '1;
    for (int k = 0; k < N; k++) i_req_waddr[5*k +: 5] = 5'(k + 1);
    @(posedge i_clk);
    @(negedge i_clk);
    cycle();
    cycle();
    chk("rst_ready", o_req_ready, 0);
    chk("rst_wen", o_rd_wen, 0);
    chk("rst_waddr", o_rd_waddr, 0);
    chk("rst_wdata", o_rd_wdata, 0);
    i_req_valid = '0;
    i_rst = 1'b0;

    // Single write from requester 1.
    i_req_valid = 3'b010;
    i_req_waddr[5 +: 5] = 5'd5;
    i_req_wdata[32 +: 32] = 32'hDEADBEEF;
    cycle();
    chk("sw_ready", obs_ready, 3'b010);
    i_req_valid = '0;
    chk("sw_wen", o_rd_wen, 1);
    chk("sw_waddr", o_rd_waddr, 5);
    chk("sw_wdata", o_rd_wdata, 32'hDEADBEEF);
    cycle();
    chk("sw_wen_drop", o_rd_wen, 0);

    // Fairness: all valid continuously.
    do_reset();
    i_req_valid = '1;
    for (int k = 0; k < N; k++) begin
      i_req_waddr[5*k +: 5]   = 5'(k + 1);
      i_req_wdata[32*k +: 32] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      exp_seq = 3'b001;
`else
      exp_seq = 3'(1 << (i % 3));
`endif
      chk("rr_gnt", obs_ready, exp_seq);
    end
    i_req_valid = '0;

    // Scoreboard: issue rd=7, writeback later.
    do_reset();
    i_rs1_addr = 5'd7;
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd7;
    cycle();
    i_issue_valid = 1'b0;
    i_issue_rd = 5'd0;
    cycle();
    chk("sb_pending", o_rs1_busy, 1);
    i_req_valid = 3'b100;
    i_req_waddr[10 +: 5] = 5'd7;
    i_req_wdata[64 +: 32] = 32'h1234_5678;
    cycle();
    i_req_valid = '0;
    chk("sb_inflight_wen", o_rd_wen, 1);
    chk("sb_inflight_busy", o_rs1_busy, 1);
    cycle();
    chk("sb_cleared", o_rs1_busy, 0);

    // Issue and writeback to reg 7 in the same cycle: set wins.
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd7;
    i_req_valid = 3'b001;
    i_req_waddr[0 +: 5] = 5'd7;
    cycle();
    i_issue_valid = 1'b0;
    i_issue_rd = 5'd0;
    i_req_valid = '0;
    cycle();
    cycle();
    chk("sb_set_wins", o_rs1_busy, 1);
    i_req_valid = 3'b001;
    cycle();
    i_req_valid = '0;
    cycle();
    chk("sb_final_clear", o_rs1_busy, 0);

    // x0 handling.
    i_rs1_addr = 5'd0;
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd0;
    cycle();
    chk("x0_rd_busy", o_rd_busy, 0);
    i_issue_valid = 1'b0;
    chk("x0_rs1_busy", o_rs1_busy, 0);
    i_req_valid = 3'b001;
    i_req_waddr[0 +: 5] = 5'd0;
    i_req_wdata[0 +: 32] = 32'hCAFE_0000;
    cycle();
    chk("x0_ready", obs_ready, 3'b001);
    i_req_valid = '0;
    chk("x0_wen", o_rd_wen, 0);
    chk("x0_waddr", o_rd_waddr, 0);
    chk("x0_wdata", o_rd_wdata, 32'hCAFE_0000);

    // Random traffic obeying the requester and issue rules.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!i_req_valid[k] && ($urandom % 3 == 0)) begin
          i_req_valid[k]          = 1'b1;
          i_req_waddr[5*k +: 5]   = 5'($urandom_range(0, 7));
          i_req_wdata[32*k +: 32] = $urandom;
        end
      end
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_issue_valid = ($urandom % 2 == 0) && !m_busy(i_issue_rd);
      i_rs1_addr    = 5'($urandom_range(0, 7));
      i_rs2_addr    = 5'($urandom_range(0, 7));
      i_rst         = ($urandom % 100 == 0);
      cycle();
      if (last_g >= 0) i_req_valid[last_g] = 1'b0;
    end
    i_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Shares the single synchronous register-file write port (wen/waddr/wdata) between NUM_REQ writeback sources, e.g. ALU pipe, load unit and multi-cycle mul/div.
- Accepts one write per cycle using a valid/ready handshake and registers the winner onto the RF write port.
- Keeps a pending-write scoreboard so issue logic can stall on RAW/WAW hazards against in-flight writes.
- Sits between the execute/memory units and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters; legal range 2..4.

Ports:
- i_clk  input  1  global clock
- i_rst  input  1  reset
- i_req_valid  input  NUM_REQ  per-requester write request
- o_req_ready  output  NUM_REQ  per-requester grant; handshake = valid & ready
- i_req_waddr  input  5*NUM_REQ  destination reg; requester k in bits [5k+4:5k]
- i_req_wdata  input  32*NUM_REQ  write data; requester k in bits [32k+31:32k]
- o_rd_wen  output  1  RF write enable (registered)
- o_rd_waddr  output  5  RF write address (registered)
- o_rd_wdata  output  32  RF write data (registered)
- i_issue_valid  input  1  an instruction writing i_issue_rd is issued this cycle
- i_issue_rd  input  5  destination of the issued instruction
- i_rs1_addr  input  5  source 1 lookup address
- i_rs2_addr  input  5  source 2 lookup address
- o_rs1_busy  output  1  source 1 has an outstanding write
- o_rs2_busy  output  1  source 2 has an outstanding write
- o_rd_busy  output  1  i_issue_rd has an outstanding write (WAW stall)

Behaviour:
- Clock and reset: i_clk is the clock; i_rst is the reset, synchronous and active-high.
- Reset values: o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, all pending bits=0, round-robin pointer=0.
- While i_rst=1, o_req_ready is all zeros.
- Arbitration:
  - Combinational; at most one ready bit per cycle, and only to a requester with valid=1.
  - Round-robin: search starts at the pointer index and wraps modulo NUM_REQ.
  - After a handshake by requester k, the pointer becomes (k+1) mod NUM_REQ.
  - With no handshake, the pointer holds.
- Requester rules:
  - Once valid is high, it must hold valid, waddr and wdata stable until its handshake.
  - o_req_ready may depend on i_req_valid, but never on the requester's own data.
- Latency: a handshake in cycle N puts that write on o_rd_* in cycle N+1; the RF commits it at the end of cycle N+1.
- Output register:
  - o_rd_wen = handshake & (waddr != 0).
  - o_rd_waddr and o_rd_wdata load on every handshake, including x0 writes.
  - With no handshake, o_rd_wen drops to 0 next cycle and addr/data hold.
- Scoreboard, 32 pending bits; bit 0 is never set:
  - Set when i_issue_valid=1 and i_issue_rd != 0.
  - Cleared at the edge ending the writeback handshake for that address.
  - Set and clear to the same register in the same cycle: set wins.
- Busy outputs:
  - busy(r) = pending[r] | (o_rd_wen & o_rd_waddr == r), with r != 0. This covers the in-flight output-register cycle so a non-bypassed RF is never read stale.
  - Address 0 is never busy.
- Issue logic must not issue to a register while o_rd_busy=1; the scoreboard holds one outstanding write per register.
- Reset mid-operation: pending bits and the output stage are discarded. A write accepted in the reset cycle is dropped, with o_rd_wen=0 the next cycle.

Optional Feature:
- Macro RF_WB_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins, and the pointer logic is removed.
- When undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package rf_wb_pkg holds:
  - REG_ADDR_W=5, XLEN=32, NUM_REG=32, NUM_REQ_MAX=4.
  - Typedef wb_req_t {valid, waddr, wdata}.
- One natural sub-module: rr_arb, NUM_REQ-wide one-hot grant with pointer update, compiled to a priority encoder when RF_WB_ARB_FIXED_PRIO_EN is defined.

Test Plan:
- Reset: hold i_rst 2 cycles with all valids=1 -> o_req_ready=0, o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, all busy=0.
- Single write: req1 valid, waddr=5, wdata=0xDEADBEEF -> ready[1]=1 the same cycle; next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0xDEADBEEF; following cycle o_rd_wen=0.
- Round-robin fairness: all 3 valid continuously with distinct addrs 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles.
- Fixed-priority build: same stimulus -> grant 0 every cycle; ready[1] and ready[2] stay 0.
- Scoreboard:
  - issue rd=7 -> o_rs1_busy=1 for rs1=7 until the writeback appears on o_rd_*, and busy also during that output cycle, then 0.
  - Issue and writeback handshake to reg 7 in the same cycle -> reg 7 stays busy.
- x0 handling: issue rd=0 -> never busy; request waddr=0 -> handshake completes, o_rd_wen stays 0.
